// File: rtl/fp_div_iter_if.sv
// Operand/result bundle between the ALU sequencer and the iterative divider.
// Start is sampled only while ready is high; done pulses once per accepted start.
interface fp_div_iter_if;
    logic        start;
    logic [31:0] fp_X;
    logic [31:0] fp_Y;
    logic [2:0]  r_mode;
    logic        ready;
    logic        done;
    logic [31:0] fp_Z;
    logic        ovrf;
    logic        udrf;

    modport master (
        output start, fp_X, fp_Y, r_mode,
        input  ready, done, fp_Z, ovrf, udrf
    );

    modport slave (
        input  start, fp_X, fp_Y, r_mode,
        output ready, done, fp_Z, ovrf, udrf
    );
endinterface

// File: rtl/fp_div_iter.sv
// binary32 divider, one restoring quotient bit per cycle; done QBITS+2 cycles after accept (1 for specials).
// No backpressure: ready is high only in IDLE, start is ignored otherwise, results are held until the next done.
module fp_div_iter #(
    parameter int          QBITS     = 26,
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_div_iter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SPECIAL, S_DIVIDE, S_ROUND} state_t;

    localparam logic [4:0]       CNT_INIT = 5'(QBITS);
    localparam logic [QBITS-2:0] LOW_MASK = {(QBITS - 1){1'b1}} >> 25;

    state_t            state_q, state_d;
    logic [31:0]       x_q, x_d;
    logic [31:0]       y_q, y_d;
    logic [2:0]        rm_q, rm_d;
    logic signed [9:0] exp_q, exp_d;
    logic [24:0]       rem_q, rem_d;
    logic [QBITS-2:0]  q_q, q_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [31:0]       z_q, z_d;
    logic              ovrf_q, ovrf_d;
    logic              udrf_q, udrf_d;
    logic              done_q, done_d;

    logic              sign;
    logic [7:0]        ex, ey;
    logic [23:0]       mx, my;
    logic              x_zero, x_inf, x_nan, y_zero, y_inf, y_nan;
    logic              in_special;
    logic [31:0]       special_z;
    logic signed [9:0] exp_raw;
    logic              ge;
    logic [23:0]       rem_sub;
    logic              lsb, g_bit, r_bit, s_bit, inc;
    logic [23:0]       frac_sum;
    logic signed [9:0] exp_post;
    logic              use_inf;

    assign sign   = x_q[31] ^ y_q[31];
    assign ex     = x_q[30:23];
    assign ey     = y_q[30:23];
    assign mx     = {1'b1, x_q[22:0]};
    assign my     = {1'b1, y_q[22:0]};
    assign x_zero = (ex == 8'h00);
    assign y_zero = (ey == 8'h00);
    assign x_inf  = (ex == 8'hFF) && (x_q[22:0] == 23'd0);
    assign y_inf  = (ey == 8'hFF) && (y_q[22:0] == 23'd0);
    assign x_nan  = (ex == 8'hFF) && (x_q[22:0] != 23'd0);
    assign y_nan  = (ey == 8'hFF) && (y_q[22:0] != 23'd0);

    // Subnormals share exp==0 with zero, so they route to SPECIAL and read as signed zero.
    assign in_special = (bus.fp_X[30:23] == 8'h00) || (bus.fp_X[30:23] == 8'hFF) ||
                        (bus.fp_Y[30:23] == 8'h00) || (bus.fp_Y[30:23] == 8'hFF);

    always_comb begin
        special_z = {sign, 31'd0};
        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
            special_z = CANON_NAN;
        end else if (x_inf || y_zero) begin
            special_z = {sign, 8'hFF, 23'd0};
        end
    end

    assign exp_raw = $signed({2'b00, ex}) - $signed({2'b00, ey}) + 10'sd127;
    assign ge      = (rem_q >= {1'b0, my});
    assign rem_sub = rem_q[23:0] - my;

    // q_q drops the integer quotient bit (always 1), so it holds frac[22:0], G, R and any extra bits.
    assign lsb      = q_q[QBITS-24];
    assign g_bit    = q_q[QBITS-25];
    assign r_bit    = q_q[QBITS-26];
    assign s_bit    = (rem_q != 25'd0) || ((q_q & LOW_MASK) != '0);
    assign frac_sum = {1'b0, q_q[QBITS-2 -: 23]} + {23'd0, inc};
    assign exp_post = exp_q + $signed({9'd0, frac_sum[23]});

    always_comb begin
        inc     = g_bit & (r_bit | s_bit | lsb);
        use_inf = 1'b1;
        case (rm_q)
            3'b001: begin
                inc     = 1'b0;
                use_inf = 1'b0;
            end
            3'b010: begin
                inc     = sign & (g_bit | r_bit | s_bit);
                use_inf = sign;
            end
            3'b011: begin
                inc     = ~sign & (g_bit | r_bit | s_bit);
                use_inf = ~sign;
            end
            3'b100:  inc = g_bit;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        rm_d    = rm_q;
        exp_d   = exp_q;
        rem_d   = rem_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        ovrf_d  = ovrf_q;
        udrf_d  = udrf_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    x_d     = bus.fp_X;
                    y_d     = bus.fp_Y;
                    rm_d    = bus.r_mode;
                    cnt_d   = CNT_INIT;
                    state_d = in_special ? S_SPECIAL : S_DIVIDE;
                end
            end
            S_SPECIAL: begin
                z_d     = special_z;
                ovrf_d  = 1'b0;
                udrf_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_DIVIDE: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == CNT_INIT) begin
                    // Pre-scale so the quotient lands in [1,2) and every iteration is a plain compare.
                    q_d = '0;
                    if (mx < my) begin
                        rem_d = {mx, 1'b0};
                        exp_d = exp_raw - 10'sd1;
                    end else begin
                        rem_d = {1'b0, mx};
                        exp_d = exp_raw;
                    end
                end else begin
                    q_d   = {q_q[QBITS-3:0], ge};
                    rem_d = ge ? {rem_sub, 1'b0} : {rem_q[23:0], 1'b0};
                    if (cnt_q == 5'd0) begin
                        state_d = S_ROUND;
                    end
                end
            end
            S_ROUND: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                ovrf_d  = 1'b0;
                udrf_d  = 1'b0;
                if (exp_q <= 10'sd0) begin
                    z_d    = {sign, 31'd0};
                    udrf_d = 1'b1;
                end else if (exp_post >= 10'sd255) begin
                    ovrf_d = 1'b1;
                    z_d    = use_inf ? {sign, 8'hFF, 23'd0} : {sign, 31'h7F7FFFFF};
                end else begin
                    z_d = {sign, exp_post[7:0], frac_sum[22:0]};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            rm_q    <= '0;
            exp_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            ovrf_q  <= 1'b0;
            udrf_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rm_q    <= rm_d;
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            ovrf_q  <= ovrf_d;
            udrf_q  <= udrf_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready = (state_q == S_IDLE);
    assign bus.done  = done_q;
    assign bus.fp_Z  = z_q;
    assign bus.ovrf  = ovrf_q;
    assign bus.udrf  = udrf_q;
endmodule
